// File: rtl/chrom_eval_scheduler.sv
// Evaluation sequencer for one chromosome: fetch vector, drive circuit, settle, compare, accumulate.
// Optional freeze input enabled by defining CHROM_SCHED_STALL_EN.
module chrom_eval_scheduler #(
  parameter int unsigned SEQ_W       = 8,
  parameter int unsigned N_OUT       = 8,
  parameter int unsigned ERR_W       = 32,
  parameter int unsigned SETTLE_BASE = 16
) (
  input  logic                   iClock,
  input  logic                   iReset,
  input  logic                   iStartProcessing,
  input  logic                   iDoneProcessingFeedback,
  input  logic [SEQ_W-1:0]       iSequencesToProcess,
  input  logic [1:0]             iSettleSel,
  output logic [SEQ_W-1:0]       oSeqIndex,
  input  logic [N_OUT-1:0]       iInputSeq,
  input  logic [N_OUT-1:0]       iExpected,
  input  logic [N_OUT-1:0]       iValid,
  output logic [N_OUT-1:0]       oCircuitInput,
  input  logic [N_OUT-1:0]       iCircuitOutput,
  input  logic                   iStall,
  output logic [N_OUT*ERR_W-1:0] oErrorSums,
  output logic                   oReadyToProcess,
  output logic                   oDoneProcessing,
  output logic [1:0]             oState
);

  // Wide enough for the largest settle length, SETTLE_BASE << 3.
  localparam int unsigned CntW = $clog2(SETTLE_BASE * 8) + 1;

  typedef enum logic [2:0] {
    StIdle, StFetch, StSettle, StCompare, StDone, StRelease
  } state_e;

  state_e           state;
  logic [SEQ_W-1:0] seq_count;
  logic [CntW-1:0]  settle_m1;
  logic [CntW-1:0]  settle_cnt;
  logic [CntW-1:0]  settle_len;
  logic [N_OUT-1:0] expected;
  logic [N_OUT-1:0] valid;
  logic [ERR_W-1:0] sums [N_OUT];
  logic             running;
  logic             stall;

  assign settle_len = CntW'(SETTLE_BASE) << iSettleSel;
  assign running    = (state == StFetch) || (state == StSettle) || (state == StCompare);

`ifdef CHROM_SCHED_STALL_EN
  assign stall = iStall && running;
`else
  logic unused_stall;
  assign unused_stall = iStall;
  assign stall        = 1'b0;
`endif

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state           <= StIdle;
      seq_count       <= '0;
      settle_m1       <= '0;
      settle_cnt      <= '0;
      expected        <= '0;
      valid           <= '0;
      oSeqIndex       <= '0;
      oCircuitInput   <= '0;
      oReadyToProcess <= 1'b1;
      oDoneProcessing <= 1'b0;
      for (int b = 0; b < int'(N_OUT); b++) sums[b] <= '0;
    end else if (!stall) begin
      unique case (state)
        StIdle: begin
          if (iStartProcessing) begin
            for (int b = 0; b < int'(N_OUT); b++) sums[b] <= '0;
            seq_count       <= iSequencesToProcess;
            settle_m1       <= settle_len - CntW'(1);
            oSeqIndex       <= '0;
            oReadyToProcess <= 1'b0;
            if (iSequencesToProcess == '0) begin
              state           <= StDone;
              oDoneProcessing <= 1'b1;
            end else begin
              state <= StFetch;
            end
          end
        end
        StFetch: begin
          expected      <= iExpected;
          valid         <= iValid;
          oCircuitInput <= iInputSeq;
          settle_cnt    <= settle_m1;
          state         <= StSettle;
        end
        StSettle: begin
          if (settle_cnt == '0) state <= StCompare;
          else                  settle_cnt <= settle_cnt - CntW'(1);
        end
        StCompare: begin
          // Saturating per-bit mismatch count.
          for (int b = 0; b < int'(N_OUT); b++) begin
            if (valid[b] && (iCircuitOutput[b] != expected[b]) && (sums[b] != '1)) begin
              sums[b] <= sums[b] + ERR_W'(1);
            end
          end
          if (oSeqIndex == seq_count - SEQ_W'(1)) begin
            state           <= StDone;
            oDoneProcessing <= 1'b1;
          end else begin
            oSeqIndex <= oSeqIndex + SEQ_W'(1);
            state     <= StFetch;
          end
        end
        StDone: begin
          if (iDoneProcessingFeedback) begin
            state           <= StRelease;
            oDoneProcessing <= 1'b0;
          end
        end
        StRelease: begin
          // Both levels must drop so a held start cannot retrigger.
          if (!iStartProcessing && !iDoneProcessingFeedback) begin
            state           <= StIdle;
            oReadyToProcess <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  always_comb begin
    oErrorSums = '0;
    for (int b = 0; b < int'(N_OUT); b++) oErrorSums[b*ERR_W +: ERR_W] = sums[b];
  end

  always_comb begin
    oState = 2'd0;
    if (stall)                                         oState = 2'd3;
    else if (running)                                  oState = 2'd1;
    else if ((state == StDone) || (state == StRelease)) oState = 2'd2;
  end

endmodule

// File: tb/tb_chrom_eval_scheduler.sv
// Directed bench for chrom_eval_scheduler; a second instance with ERR_W=4 checks saturation.
module tb_chrom_eval_scheduler;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         fb = 1'b0;
  logic [7:0]   nseq = '0;
  logic [1:0]   sel = '0;
  logic         stall = 1'b0;
  logic [7:0]   seq_index, seq_index4;
  logic [7:0]   circ_in, circ_in4;
  logic [7:0]   circ_out;
  logic [255:0] err_sums;
  logic [31:0]  err_sums4;
  logic         ready, done, ready4, done4;
  logic [1:0]   state, state4;
  logic         out_const_en = 1'b0;
  logic [7:0]   out_const = '0;
  logic [7:0]   in_mem  [256];
  logic [7:0]   exp_mem [256];
  logic [7:0]   val_mem [256];
  logic [7:0]   input_seq, expected, valid;

  int tests = 0;
  int fails = 0;
  int cycles;

  always #5 clk = ~clk;

  assign input_seq = in_mem[seq_index];
  assign expected  = exp_mem[seq_index];
  assign valid     = val_mem[seq_index];
  assign circ_out  = out_const_en ? out_const : circ_in;

  chrom_eval_scheduler dut (
    .iClock(clk), .iReset(rst), .iStartProcessing(start), .iDoneProcessingFeedback(fb),
    .iSequencesToProcess(nseq), .iSettleSel(sel), .oSeqIndex(seq_index),
    .iInputSeq(input_seq), .iExpected(expected), .iValid(valid), .oCircuitInput(circ_in),
    .iCircuitOutput(circ_out), .iStall(stall), .oErrorSums(err_sums),
    .oReadyToProcess(ready), .oDoneProcessing(done), .oState(state)
  );

  chrom_eval_scheduler #(.ERR_W(4)) dut4 (
    .iClock(clk), .iReset(rst), .iStartProcessing(start), .iDoneProcessingFeedback(fb),
    .iSequencesToProcess(nseq), .iSettleSel(sel), .oSeqIndex(seq_index4),
    .iInputSeq(input_seq), .iExpected(expected), .iValid(valid), .oCircuitInput(circ_in4),
    .iCircuitOutput(circ_out), .iStall(stall), .oErrorSums(err_sums4),
    .oReadyToProcess(ready4), .oDoneProcessing(done4), .oState(state4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sum_of(input int b);
    return err_sums[b*32 +: 32];
  endfunction

  // Counts edges from the first edge that samples start until done is seen.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!done && n < 4000);
  endtask

  task automatic release_run();
    fb = 1'b1;
    step(1);
    start = 1'b0;
    fb    = 1'b0;
    step(1);
  endtask

  task automatic fill(input logic [7:0] base, input logic [7:0] flip, input logic [7:0] v);
    for (int i = 0; i < 256; i++) begin
      in_mem[i]  = base ^ 8'(i * 7);
      exp_mem[i] = in_mem[i] ^ flip;
      val_mem[i] = v;
    end
  endtask

  initial begin
    fill(8'h3C, 8'h00, 8'hFF);
    step(2);
    rst = 1'b0;
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_state", state, 0);
    check("rst_idx", seq_index, 0);
    check("rst_cin", circ_in, 0);
    check("rst_sums", err_sums, 0);

    // N = 0: straight to done; held start must not retrigger from release.
    nseq = 0; start = 1'b1;
    step(2);
    check("n0_done", done, 1);
    check("n0_state", state, 2);
    check("n0_sums", err_sums, 0);
    fb = 1'b1;
    step(1);
    check("n0_rel_done", done, 0);
    fb = 1'b0;
    step(2);
    check("n0_hold_start", ready, 0);
    start = 1'b0;
    step(1);
    check("n0_ready", ready, 1);

    // Identity circuit, N=3, S=16: 3*18+1 edges.
    nseq = 3; sel = 0; start = 1'b1;
    wait_done(cycles);
    check("t2_cycles", cycles, 55);
    check("t2_sums", err_sums, 0);
    step(3);
    check("t2_done_held", done, 1);
    release_run();

    // Stuck 0x00 vs expected 0xFF, mask 0x0F; selector change mid-run ignored.
    fill(8'h11, 8'hFF, 8'h0F);
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'hFF;
    out_const_en = 1'b1; out_const = 8'h00;
    nseq = 4; start = 1'b1;
    step(1);
    sel = 3;
    wait_done(cycles);
    check("t3_cycles", cycles + 1, 73);
    check("t3_sum0", sum_of(0), 4);
    check("t3_sum3", sum_of(3), 4);
    check("t3_sum4", sum_of(4), 0);
    check("t3_sum7", sum_of(7), 0);
    release_run();

    // S=32, bit 0 always wrong, bit 7 wrong but masked.
    fill(8'hA5, 8'h81, 8'h01);
    out_const_en = 1'b0;
    nseq = 2; sel = 1; start = 1'b1;
    wait_done(cycles);
    check("s1_cycles", cycles, 69);
    check("s1_sum0", sum_of(0), 2);
    check("s1_sum7", sum_of(7), 0);
    release_run();

    // 20 mismatches on bit 0: 32-bit sum reaches 20, 4-bit sum pins at 15.
    fill(8'h00, 8'h01, 8'h01);
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'h01;
    out_const_en = 1'b1; out_const = 8'h00;
    nseq = 20; sel = 0; start = 1'b1;
    wait_done(cycles);
    check("sat_cycles", cycles, 361);
    check("sat_wide", sum_of(0), 20);
    check("sat_narrow0", err_sums4[3:0], 15);
    check("sat_narrow1", err_sums4[7:4], 0);
    release_run();

    // Reset during SETTLE of the second sequence aborts everything.
    fill(8'h5A, 8'hFF, 8'hFF);
    nseq = 3; start = 1'b1;
    cycles = 0;
    do begin
      step(1);
      cycles++;
    end while (seq_index != 1 && cycles < 200);
    check("r_reach_seq1", seq_index, 1);
    step(5);
    check("r_pre_sum0", sum_of(0), 1);
    check("r_pre_cin", circ_in, in_mem[1]);
    rst = 1'b1; start = 1'b0;
    step(1);
    check("r_ready", ready, 1);
    check("r_state", state, 0);
    check("r_sums", err_sums, 0);
    check("r_cin", circ_in, 0);
    check("r_idx", seq_index, 0);
    rst = 1'b0;
    step(1);

    // Stall for 10 edges inside SETTLE.
    fill(8'h3C, 8'h00, 8'hFF);
    out_const_en = 1'b0;
    nseq = 3; sel = 0; start = 1'b1;
    step(5);
    stall = 1'b1;
    step(1);
`ifdef CHROM_SCHED_STALL_EN
    check("st_state", state, 3);
`else
    check("st_state", state, 1);
`endif
    step(9);
    stall = 1'b0;
    wait_done(cycles);
`ifdef CHROM_SCHED_STALL_EN
    check("st_cycles", cycles + 15, 65);
`else
    check("st_cycles", cycles + 15, 55);
`endif
    check("st_sums", err_sums, 0);
    stall = 1'b1;
    step(2);
    check("st_done_ignores", state, 2);
    stall = 1'b0;
    release_run();
    check("end_ready", ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
